// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
// State encoding, read latency and drain length live here so the top level
// and the read tracker agree on them.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_t;

  localparam int MEM_LATENCY  = 2;
  localparam int DRAIN_CYCLES = 2;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);

  // Ownership state for a given requester index.
  function automatic arb_state_t own_state(input logic who);
    return who ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_tracker.sv
// Read-latency tracker: a MEM_LATENCY-deep shift register carrying a valid
// bit plus the requester tag of each issued read, so returning data can be
// routed to the requester that asked for it.
module rd_tracker
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic owner,
  output logic valid0,
  output logic valid1
);

  logic [MEM_LATENCY-1:0] vld_reg;
  logic [MEM_LATENCY-1:0] tag_reg;
  logic [MEM_LATENCY-1:0] vld_next;
  logic [MEM_LATENCY-1:0] tag_next;

  // Stage 0 takes the new read; every later stage takes its predecessor.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign vld_next[gi] = issue;
        assign tag_next[gi] = owner;
      end else begin : g_body
        assign vld_next[gi] = vld_reg[gi-1];
        assign tag_next[gi] = tag_reg[gi-1];
      end
    end
  endgenerate

  // Advance the pipeline; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg <= '0;
      tag_reg <= '0;
    end else begin
      vld_reg <= vld_next;
      tag_reg <= tag_next;
    end
  end

  assign valid0 = vld_reg[MEM_LATENCY-1] & ~tag_reg[MEM_LATENCY-1];
  assign valid1 = vld_reg[MEM_LATENCY-1] &  tag_reg[MEM_LATENCY-1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (instruction cache = 0, data cache = 1).
// A requester owns memory for a whole burst; after release the arbiter
// drains for DRAIN_CYCLES before arbitrating again. Ties are round-robin,
// or always go to requester 1 when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        memRead0,
  input  logic        memRead1,
  input  logic        memWrite0,
  input  logic        memWrite1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] memDataIn,
  output logic        memRead,
  output logic        memWrite,
  output logic [15:0] memAddr,
  output logic [15:0] memDataOut,
  output logic        grant0,
  output logic        grant1,
  output logic [15:0] rdData,
  output logic        rdValid0,
  output logic        rdValid1,
  output logic        busy,
  output logic        err
);

  arb_state_t         state_reg, state_next;
  logic               grant0_reg, grant0_next;
  logic               grant1_reg, grant1_next;
  logic               last_grant_reg, last_grant_next;
  logic               owner_reg, owner_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic               err_reg, err_next;

  logic               tie_win;
  logic               win;
  logic               sel;
  logic               own_req, own_rd, own_wr;
  logic [15:0]        own_addr, own_wdata;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign tie_win = 1'b1;
`else
  assign tie_win = ~last_grant_reg;
`endif

  // Requester selected by the current ownership state.
  assign sel       = (state_reg == ST_OWN1);
  assign own_req   = sel ? req1      : req0;
  assign own_rd    = sel ? memRead1  : memRead0;
  assign own_wr    = sel ? memWrite1 : memWrite0;
  assign own_addr  = sel ? addr1     : addr0;
  assign own_wdata = sel ? wdata1    : wdata0;

  // Register the arbitration state, grants and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant0_reg     <= 1'b0;
      grant1_reg     <= 1'b0;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      drain_cnt_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant0_reg     <= grant0_next;
      grant1_reg     <= grant1_next;
      last_grant_reg <= last_grant_next;
      owner_reg      <= owner_next;
      drain_cnt_reg  <= drain_cnt_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic and the combinational memory-side command path.
  always_comb begin
    state_next      = state_reg;
    grant0_next     = grant0_reg;
    grant1_next     = grant1_reg;
    last_grant_next = last_grant_reg;
    owner_next      = owner_reg;
    drain_cnt_next  = drain_cnt_reg;
    err_next        = 1'b0;
    win             = 1'b0;
    memRead         = 1'b0;
    memWrite        = 1'b0;
    memAddr         = '0;
    memDataOut      = '0;

    case (state_reg)
      ST_IDLE: begin
        if (req0 || req1) begin
          win             = (req0 && req1) ? tie_win : req1;
          state_next      = own_state(win);
          owner_next      = win;
          last_grant_next = win;
          grant0_next     = ~win;
          grant1_next     = win;
        end
      end
      ST_OWN0, ST_OWN1: begin
        memAddr    = own_addr;
        memDataOut = own_wdata;
        // A simultaneous read+write is suppressed and flagged next cycle.
        if (own_rd && own_wr) begin
          err_next = 1'b1;
        end else begin
          memRead  = own_rd;
          memWrite = own_wr;
        end
        if (!own_req) begin
          state_next     = ST_DRAIN;
          drain_cnt_next = DRAIN_W'(DRAIN_CYCLES);
          grant0_next    = 1'b0;
          grant1_next    = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_reg <= DRAIN_W'(1)) begin
          drain_cnt_next = '0;
          state_next     = ST_IDLE;
        end else begin
          drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Owner tag is held through DRAIN so late read data still routes correctly.
  rd_tracker u_rd_tracker (
    .clk    (clk),
    .rst    (rst),
    .issue  (memRead),
    .owner  (owner_reg),
    .valid0 (rdValid0),
    .valid1 (rdValid1)
  );

  assign grant0 = grant0_reg;
  assign grant1 = grant1_reg;
  assign err    = err_reg;
  assign busy   = (state_reg != ST_IDLE);
  assign rdData = memDataIn;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed bursts followed by random
// traffic, compared every cycle against a cycle-count reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic        memRead0, memRead1, memWrite0, memWrite1;
  logic [15:0] addr0, addr1, wdata0, wdata1, memDataIn;
  logic        memRead, memWrite;
  logic [15:0] memAddr, memDataOut, rdData;
  logic        grant0, grant1, rdValid0, rdValid1, busy, err;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .memRead0(memRead0), .memRead1(memRead1),
    .memWrite0(memWrite0), .memWrite1(memWrite1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .memDataIn(memDataIn), .memRead(memRead), .memWrite(memWrite),
    .memAddr(memAddr), .memDataOut(memDataOut),
    .grant0(grant0), .grant1(grant1), .rdData(rdData),
    .rdValid0(rdValid0), .rdValid1(rdValid1), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: who owns memory (-1 none), drain cycles left,
  // last winner, pending error pulse, and read returns keyed by cycle.
  int m_own   = -1;
  int m_drain = 0;
  int m_last  = 1;
  bit m_err   = 1'b0;
  int rdv_map[int];
  bit exp_issue;
  bit exp_both;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0;
    memRead0 = 0; memRead1 = 0; memWrite0 = 0; memWrite1 = 0;
    addr0 = 16'h0; addr1 = 16'h0; wdata0 = 16'h0; wdata1 = 16'h0;
    memDataIn = 16'($urandom);
  endtask

  task automatic compare_outputs();
    logic        o_rd, o_wr;
    logic [15:0] o_a, o_d;
    int          v;
    o_rd = 0; o_wr = 0; o_a = 16'h0; o_d = 16'h0;
    exp_both = 0;
    if (m_own == 0) begin
      exp_both = memRead0 && memWrite0;
      o_rd = memRead0 && !exp_both;
      o_wr = memWrite0 && !exp_both;
      o_a = addr0; o_d = wdata0;
    end else if (m_own == 1) begin
      exp_both = memRead1 && memWrite1;
      o_rd = memRead1 && !exp_both;
      o_wr = memWrite1 && !exp_both;
      o_a = addr1; o_d = wdata1;
    end
    exp_issue = o_rd;
    v = rdv_map.exists(cyc) ? rdv_map[cyc] : -1;
    chk("grant0", grant0, m_own == 0);
    chk("grant1", grant1, m_own == 1);
    chk("busy", busy, (m_own >= 0) || (m_drain > 0));
    chk("err", err, m_err);
    chk("memRead", memRead, o_rd);
    chk("memWrite", memWrite, o_wr);
    chk("memAddr", memAddr, o_a);
    chk("memDataOut", memDataOut, o_d);
    chk("rdValid0", rdValid0, v == 0);
    chk("rdValid1", rdValid1, v == 1);
    chk("rdData", rdData, memDataIn);
  endtask

  task automatic model_reset();
    m_own = -1; m_drain = 0; m_last = 1; m_err = 0;
    rdv_map.delete();
  endtask

  task automatic model_step();
    int win;
    if (rst) begin
      model_reset();
      return;
    end
    if (rdv_map.exists(cyc)) rdv_map.delete(cyc);
    m_err = exp_both;
    if (exp_issue) rdv_map[cyc + 2] = m_own;
    if (m_own >= 0) begin
      if (!((m_own == 0) ? req0 : req1)) begin
        m_own = -1;
        m_drain = 2;
      end
    end else if (m_drain > 0) begin
      m_drain--;
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        win = 1;
`else
        win = 1 - m_last;
`endif
      end else begin
        win = req1 ? 1 : 0;
      end
      m_own = win;
      m_last = win;
      $display("cycle %0d: grant -> requester %0d (req0=%0b req1=%0b)", cyc, win, req0, req1);
    end
  endtask

  // One clock: check outputs mid-cycle, advance DUT and model together.
  task automatic step();
    #1;
    compare_outputs();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;

    // Simultaneous requests straight after reset, then hand-over after drain.
    req0 = 1; req1 = 1;
    repeat (3) step();
    req0 = 0;
    repeat (5) step();
    req1 = 0;
    repeat (5) step();

    // Requester 1 burst with reads at offsets 0,2,4,6; last data lands in DRAIN.
    req1 = 1;
    step();
    for (int k = 0; k < 7; k++) begin
      memRead1 = (k % 2 == 0);
      addr1 = 16'h1230 + 16'(k);
      memDataIn = 16'($urandom);
      step();
    end
    memRead1 = 0; req1 = 0;
    repeat (6) step();

    // Illegal read+write by owner 0 while non-owner 1 tries to write 0xFFFE.
    req0 = 1;
    step();
    memRead0 = 1; memWrite0 = 1; addr0 = 16'h0040; wdata0 = 16'hA5A5;
    req1 = 1; memWrite1 = 1; addr1 = 16'hFFFE; wdata1 = 16'h5A5A;
    step();
    memRead0 = 0; memWrite0 = 0;
    repeat (2) step();

    // Reset in the middle of an OWN0 burst with reads in flight.
    memRead0 = 1; addr0 = 16'h0100;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    repeat (4) step();

    // Random bursty traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req0 = req0 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      req1 = req1 ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      memRead0 = 1'($urandom_range(0, 1));
      memRead1 = 1'($urandom_range(0, 1));
      memWrite0 = ($urandom_range(0, 3) == 0);
      memWrite1 = ($urandom_range(0, 3) == 0);
      addr0 = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      addr1 = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      wdata0 = 16'($urandom);
      wdata1 = 16'($urandom);
      memDataIn = 16'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk input 1 (single clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have req0/req1 input 1 each: memory-ownership request from requester 0 (instruction cache controller) and requester 1 (data cache controller), held high for a whole burst.
REQ-003 SHALL have memRead0/memRead1 and memWrite0/memWrite1 input 1 each: per-requester memory command.
REQ-004 SHALL have addr0/addr1 and wdata0/wdata1 input 16 each: per-requester address and write data.
REQ-005 SHALL have memDataIn input 16: read data returned by the four-banked memory.
REQ-006 SHALL have memRead, memWrite output 1 and memAddr, memDataOut output 16: commands and data to memory.
REQ-007 SHALL have grant0, grant1 output 1: registered ownership indication.
REQ-008 SHALL have rdData output 16, rdValid0 and rdValid1 output 1: returned read data, tagged per requester.
REQ-009 SHALL have busy output 1 (state != IDLE) and err output 1 (illegal command pulse).

Function
REQ-010 SHALL implement states IDLE, OWN0, OWN1, DRAIN.
REQ-011 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not equal to lastGrant; neither -> IDLE.
REQ-012 Grant SHALL be registered: grantN rises the cycle after the IDLE decision, and lastGrant updates on that same edge.
REQ-013 In OWNn, memRead/memWrite/memAddr/memDataOut SHALL be driven combinationally from requester n; all other requester inputs are ignored.
REQ-014 In OWNn, if reqn = 0, the next state SHALL be DRAIN with drainCnt = 2, and grantN SHALL fall on that edge.
REQ-015 In DRAIN, memRead/memWrite SHALL be 0; drainCnt decrements each cycle; at 0 the next state SHALL be IDLE.
REQ-016 A request arriving during OWN or DRAIN SHALL wait; no preemption is allowed.
REQ-017 SHALL track reads with a 2-deep shift register: a memRead issued at cycle t produces rdValidOwner = 1 at cycle t+2, with rdData = memDataIn.
REQ-018 The read-valid tag SHALL be the owner register, held through DRAIN so late data routes correctly.
REQ-019 If the owner asserts memRead and memWrite together, memory SHALL see neither, and err SHALL pulse high for exactly the next cycle.
REQ-020 When there is no owner, memAddr and memDataOut SHALL be 0.

Reset
REQ-021 While rst = 1 at a clk edge, the block SHALL enter IDLE with: grant0/1 = 0, lastGrant = 1 (requester 0 wins the first tie), drainCnt = 0, tracker cleared, rdValid0/1 = 0, err = 0, busy = 0.
REQ-022 A reset mid-burst SHALL discard all in-flight reads; no rdValid is produced after reset.

Configuration
REQ-023 With macro MEM_ARB_FIXED_PRIO_EN defined, the IDLE tie SHALL always go to requester 1; lastGrant is not consulted.
REQ-024 Without MEM_ARB_FIXED_PRIO_EN, tie-breaking SHALL be round-robin per REQ-011.

Structure
REQ-025 A shared package mem_arb_pkg SHALL hold the state encoding, MEM_LATENCY = 2 and DRAIN_CYCLES = 2.
REQ-026 The read-latency shift register SHALL be a sub-module named rd_tracker, with ports clk, rst, issue, owner in; valid0, valid1 out.

Verification
REQ-027 Reset, then req0 = req1 = 1 in the same cycle -> grant0 = 1 the next cycle; after req0 drops, 2 DRAIN cycles, 1 IDLE cycle, then grant1 = 1.
REQ-028 OWN1 with reads at offsets 0, 2, 4, 6 (addr 0x1230..0x1236), then req1 drops -> rdValid1 is high for 4 cycles starting 2 cycles after the first read, including during DRAIN; rdValid0 stays 0.
REQ-029 Owner asserts memRead = memWrite = 1 at addr 0x0040 -> memory sees 0/0, err = 1 for one cycle, and the state is unchanged.
REQ-030 Non-owner drives memWrite = 1, addr 0xFFFE while the other requester owns -> memAddr follows the owner only; no write to 0xFFFE.
REQ-031 rst = 1 asserted during OWN0, with reads in flight -> the next cycle shows IDLE, grant0 = 0, and no rdValid pulses.
REQ-032 With MEM_ARB_FIXED_PRIO_EN defined, repeated simultaneous req0/req1 -> requester 1 is granted every arbitration.
